// File: rtl/preemption_scheduler.sv
// preemption_scheduler: emergency-vehicle preemption sequencer producing override lamps for the intersection.
// Ports: clk, rst (async, active-low); preempt_req_ns/ew raw request levels;
//   ns/ew_green_active normal-FSM status; override_en lamp-mux select;
//   ovr_{ns,ew}_{green,yellow,red} override lamps; preempt_dir (0 NS, 1 EW);
//   ped_inhibit (only driven with PREEMPT_PED_CLEAR_EN defined); serve_done exit pulse.
module preemption_scheduler #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int YELLOW_TIME   = 5,
    parameter int ALL_RED_TIME  = 2,
    parameter int MIN_HOLD_TIME = 10,
    parameter int MAX_HOLD_TIME = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic preempt_req_ns,
    input  logic preempt_req_ew,
    input  logic ns_green_active,
    input  logic ew_green_active,
    output logic override_en,
    output logic ovr_ns_green,
    output logic ovr_ns_yellow,
    output logic ovr_ns_red,
    output logic ovr_ew_green,
    output logic ovr_ew_yellow,
    output logic ovr_ew_red,
    output logic preempt_dir,
    output logic ped_inhibit,
    output logic serve_done
);
    // 64-bit products: MAX_HOLD_TIME*CLK_FREQ overflows a 32-bit int at the defaults
    localparam logic [31:0] YEL_END = 32'(64'(YELLOW_TIME) * 64'(CLK_FREQ) - 64'd1);
    localparam logic [31:0] RED_END = 32'(64'(ALL_RED_TIME) * 64'(CLK_FREQ) - 64'd1);
    localparam logic [31:0] MIN_END = 32'(64'(MIN_HOLD_TIME) * 64'(CLK_FREQ) - 64'd1);
    localparam logic [31:0] MAX_END = 32'(64'(MAX_HOLD_TIME) * 64'(CLK_FREQ) - 64'd1);
    typedef enum logic [2:0] {IDLE, EXIT_YELLOW, CLEAR_RED, SERVE, RELEASE_RED} state_t;
    state_t state, state_n;
    logic [1:0] sync_ns, sync_ew;
    logic [31:0] cnt;
    logic req_ns, req_ew, req_w, req_o;
    logic dir, dir_n, ptr, ptr_n, max_hit, serve_exit;
    assign req_ns = sync_ns[1];
    assign req_ew = sync_ew[1];
    assign req_w = dir ? req_ew : req_ns;
    assign req_o = dir ? req_ns : req_ew;
    assign serve_exit = state == SERVE && ((cnt >= MIN_END && !req_w) || cnt == MAX_END);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ns    <= '0;
            sync_ew    <= '0;
            state      <= IDLE;
            cnt        <= '0;
            dir        <= 1'b0;
            ptr        <= 1'b0;
            max_hit    <= 1'b0;
            serve_done <= 1'b0;
        end else begin
            sync_ns    <= {sync_ns[0], preempt_req_ns};
            sync_ew    <= {sync_ew[0], preempt_req_ew};
            state      <= state_n;
            cnt        <= (state_n != state || state == IDLE) ? '0 : cnt + 32'd1;
            dir        <= dir_n;
            ptr        <= ptr_n;
            max_hit    <= serve_exit ? (cnt == MAX_END) : max_hit;
            serve_done <= serve_exit;
        end
    end
    always_comb begin
        state_n = state;
        dir_n   = dir;
        ptr_n   = ptr;
        case (state)
            IDLE: if (req_ns || req_ew) begin
                dir_n   = (req_ns && req_ew) ? ptr : req_ew;
                ptr_n   = (req_ns && req_ew) ? !ptr : ptr;
                // a lit conflicting approach (including both lit) must clear through yellow
                state_n = (dir_n ? ns_green_active : ew_green_active) ? EXIT_YELLOW :
                          (dir_n ? ew_green_active : ns_green_active) ? SERVE : CLEAR_RED;
            end
            EXIT_YELLOW: state_n = cnt == YEL_END ? CLEAR_RED : EXIT_YELLOW;
            CLEAR_RED:   state_n = cnt == RED_END ? SERVE : CLEAR_RED;
            SERVE:       state_n = serve_exit ? RELEASE_RED : SERVE;
            RELEASE_RED: if (cnt == RED_END) begin
                if (req_o) begin
                    dir_n   = !dir;
                    ptr_n   = !ptr;
                    state_n = SERVE;
                end else begin
                    state_n = (req_w && max_hit) ? SERVE : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    assign override_en   = state != IDLE;
    assign preempt_dir   = dir;
    assign ovr_ns_green  = state == SERVE && !dir;
    assign ovr_ew_green  = state == SERVE && dir;
    assign ovr_ns_yellow = state == EXIT_YELLOW && dir;
    assign ovr_ew_yellow = state == EXIT_YELLOW && !dir;
    assign ovr_ns_red    = !ovr_ns_green && !ovr_ns_yellow;
    assign ovr_ew_red    = !ovr_ew_green && !ovr_ew_yellow;
`ifdef PREEMPT_PED_CLEAR_EN
    assign ped_inhibit = state != IDLE;
`else
    assign ped_inhibit = 1'b0;
`endif
endmodule

// File: tb/tb_preemption_scheduler.sv
// tb_preemption_scheduler: table-driven check of takeover, hold, arbitration and reset behaviour.
module tb_preemption_scheduler;
    logic clk = 1'b0, rst = 1'b0;
    logic preempt_req_ns = 1'b0, preempt_req_ew = 1'b0, ns_green_active = 1'b0, ew_green_active = 1'b0;
    logic override_en, ovr_ns_green, ovr_ns_yellow, ovr_ns_red, ovr_ew_green, ovr_ew_yellow, ovr_ew_red;
    logic preempt_dir, ped_inhibit, serve_done;
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    preemption_scheduler #(
        .CLK_FREQ(10), .YELLOW_TIME(3), .ALL_RED_TIME(2), .MIN_HOLD_TIME(5), .MAX_HOLD_TIME(20)
    ) dut (
        .clk(clk), .rst(rst),
        .preempt_req_ns(preempt_req_ns), .preempt_req_ew(preempt_req_ew),
        .ns_green_active(ns_green_active), .ew_green_active(ew_green_active),
        .override_en(override_en),
        .ovr_ns_green(ovr_ns_green), .ovr_ns_yellow(ovr_ns_yellow), .ovr_ns_red(ovr_ns_red),
        .ovr_ew_green(ovr_ew_green), .ovr_ew_yellow(ovr_ew_yellow), .ovr_ew_red(ovr_ew_red),
        .preempt_dir(preempt_dir), .ped_inhibit(ped_inhibit), .serve_done(serve_done)
    );
    // pattern = {override_en, dir (when enabled), ns g/y/r, ew g/y/r}
    localparam logic [7:0] IDL  = 8'b00_001_001;
    localparam logic [7:0] EY_N = 8'b10_001_010;
    localparam logic [7:0] RD_N = 8'b10_001_001;
    localparam logic [7:0] SV_N = 8'b10_100_001;
    localparam logic [7:0] EY_E = 8'b11_010_001;
    localparam logic [7:0] RD_E = 8'b11_001_001;
    localparam logic [7:0] SV_E = 8'b11_001_100;
    // in = {rst, req_ns, req_ew, ns_green_active, ew_green_active}, held for len cycles
    typedef struct {
        logic [4:0] in;
        int         len;
        logic [7:0] exp;
        int         sd;
    } rec_t;
    rec_t tbl[$];
    function automatic void add(logic [4:0] i, int l, logic [7:0] e, int s);
        tbl.push_back('{i, l, e, s});
    endfunction
    task automatic check(string nm, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask
    initial begin
        logic [7:0] act, got;
        logic exp_ped, got_ped;
        int sd, at;
        bit bad;
        // conflicting takeover: EW lit, one-cycle NS pulse
        add(5'b11001, 1, IDL, 0); add(5'b10001, 2, IDL, 0); add(5'b10001, 30, EY_N, 0);
        add(5'b10001, 20, RD_N, 0); add(5'b10001, 50, SV_N, 0); add(5'b10001, 20, RD_N, 1);
        add(5'b10001, 3, IDL, 0);
        // same direction already green: straight to SERVE, request held 100 cycles
        add(5'b11010, 3, IDL, 0); add(5'b11010, 97, SV_N, 0); add(5'b10010, 3, SV_N, 0);
        add(5'b10010, 20, RD_N, 1); add(5'b10010, 3, IDL, 0);
        // simultaneous requests after reset, held 300 cycles
        add(5'b00000, 2, IDL, 0);
        add(5'b11100, 3, IDL, 0); add(5'b11100, 20, RD_N, 0); add(5'b11100, 200, SV_N, 0);
        add(5'b11100, 20, RD_N, 1); add(5'b11100, 57, SV_E, 0); add(5'b10000, 3, SV_E, 0);
        add(5'b10000, 20, RD_E, 1); add(5'b10000, 3, IDL, 0);
        // round robin: pointer back at NS, then EW
        add(5'b11100, 1, IDL, 0); add(5'b10000, 2, IDL, 0); add(5'b10000, 20, RD_N, 0);
        add(5'b10000, 50, SV_N, 0); add(5'b10000, 20, RD_N, 1); add(5'b10000, 3, IDL, 0);
        add(5'b11100, 1, IDL, 0); add(5'b10000, 2, IDL, 0); add(5'b10000, 20, RD_E, 0);
        add(5'b10000, 50, SV_E, 0); add(5'b10000, 20, RD_E, 1); add(5'b10000, 3, IDL, 0);
        // max hold: EW stuck high, re-served, then dropped
        add(5'b10100, 3, IDL, 0); add(5'b10100, 20, RD_E, 0); add(5'b10100, 200, SV_E, 0);
        add(5'b10100, 20, RD_E, 1); add(5'b10100, 200, SV_E, 0); add(5'b10100, 20, RD_E, 1);
        add(5'b10100, 50, SV_E, 0); add(5'b10000, 3, SV_E, 0); add(5'b10000, 20, RD_E, 1);
        add(5'b10000, 3, IDL, 0);
        // illegal both-lit status: EW winner, NS yellow
        add(5'b10111, 1, IDL, 0); add(5'b10011, 2, IDL, 0); add(5'b10011, 30, EY_E, 0);
        add(5'b10011, 20, RD_E, 0); add(5'b10011, 50, SV_E, 0); add(5'b10011, 20, RD_E, 1);
        add(5'b10011, 3, IDL, 0);
        // async reset mid-SERVE after pointer moved to EW; pointer must return to NS
        add(5'b11100, 1, IDL, 0); add(5'b10000, 2, IDL, 0); add(5'b10000, 20, RD_N, 0);
        add(5'b10000, 10, SV_N, 0); add(5'b00000, 1, IDL, 0);
        add(5'b11100, 1, IDL, 0); add(5'b10000, 2, IDL, 0); add(5'b10000, 20, RD_N, 0);
        add(5'b10000, 50, SV_N, 0); add(5'b10000, 20, RD_N, 1); add(5'b10000, 3, IDL, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset override_en", 32'(override_en), 32'd0);
        check("reset ns lamps", 32'({ovr_ns_green, ovr_ns_yellow, ovr_ns_red}), 32'b001);
        check("reset ew lamps", 32'({ovr_ew_green, ovr_ew_yellow, ovr_ew_red}), 32'b001);
        check("reset dir/done/ped", 32'({preempt_dir, serve_done, ped_inhibit}), 32'd0);
        foreach (tbl[i]) begin
            bad = 0; sd = 0; at = 0; got = '0; got_ped = 1'b0;
`ifdef PREEMPT_PED_CLEAR_EN
            exp_ped = tbl[i].exp[7];
`else
            exp_ped = 1'b0;
`endif
            for (int c = 0; c < tbl[i].len; c++) begin
                {rst, preempt_req_ns, preempt_req_ew, ns_green_active, ew_green_active} = tbl[i].in;
                #1;
                act = {override_en, override_en & preempt_dir, ovr_ns_green, ovr_ns_yellow, ovr_ns_red,
                       ovr_ew_green, ovr_ew_yellow, ovr_ew_red};
                if (!bad && (act !== tbl[i].exp || ped_inhibit !== exp_ped)) begin
                    bad = 1; at = c; got = act; got_ped = ped_inhibit;
                end
                sd += int'(serve_done);
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (bad || sd != tbl[i].sd) begin
                n_bad++;
                $display("FAIL rec%0d cycle %0d: lamps got %b want %b, ped got %b want %b, serve_done pulses got %0d want %0d",
                         i, at, got, tbl[i].exp, got_ped, exp_ped, sd, tbl[i].sd);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
